// File: rtl/mfp_multi_digit_seven_segment_scanner.sv
// Time-multiplexed hex display scanner with a double-buffered frame and anti-ghosting blanking.
// Optional build macro MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module mfp_multi_digit_seven_segment_scanner #(
  parameter int unsigned N_DIGITS         = 8,
  parameter int unsigned SCAN_DIV         = 50000,
  parameter int unsigned BLANK_CYCLES     = 500,
  parameter int unsigned SEG_ACTIVE_LOW   = 1,
  parameter int unsigned ANODE_ACTIVE_LOW = 1
) (
  input  logic                    SI_ClkIn,
  input  logic                    SI_Reset,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [N_DIGITS-1:0]     digit_en,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [N_DIGITS-1:0]     anode,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Inactive levels; XOR with these converts active-high codes to pin polarity.
  localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                    : {N_DIGITS{1'b0}};

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  localparam state_e S_RST = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  state_e              state_q, state_d;
  logic [VAL_W-1:0]    shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0] shadow_en_q, shadow_en_d;
  logic [VAL_W-1:0]    pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0] pend_en_q, pend_en_d;
  logic                upd_q, upd_d;
  logic                fd_q, fd_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                wrap_c;
  logic [3:0]          digit_c;
  logic [N_DIGITS-1:0] lz_blank_c;

  // Digits above the most significant non-zero nibble; digit 0 is never blanked.
`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
  always_comb begin : lz_mask
    logic seen;
    seen       = 1'b0;
    lz_blank_c = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      seen          = seen | (shadow_val_q[4*i +: 4] != 4'h0);
      lz_blank_c[i] = ~seen;
    end
  end
`else
  assign lz_blank_c = '0;
`endif

  assign digit_c = shadow_val_q[4*idx_q +: 4];

  // Scan position, slot phase and the double-buffered frame data.
  always_comb begin : next_state
    wrap_c       = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    if (cnt_q == CNT_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    state_d      = (32'(cnt_d) >= BLANK_CYCLES) ? S_DRIVE : S_BLANK;

    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_en_d  = shadow_en_q;
    upd_d        = upd_q;

    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
      pend_en_d  = digit_en;
    end

    // Shadow only changes on the frame boundary so a frame is never torn.
    if (wrap_c) begin
      upd_d = 1'b0;
      if (load) begin
        shadow_val_d = value;
        shadow_dp_d  = dp;
        shadow_en_d  = digit_en;
      end else if (upd_q) begin
        shadow_val_d = pend_val_q;
        shadow_dp_d  = pend_dp_q;
        shadow_en_d  = pend_en_q;
      end
    end else if (load) begin
      upd_d = 1'b1;
    end

    // Pulse spans the cycle that ends on the wrap edge, so a load seen with it lands in shadow.
    fd_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  // Pin drive for the current scan position, registered one cycle later.
  always_comb begin : drive
    logic [6:0] seg_ah;
    seg_ah = 7'h00;
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    an_d   = AN_OFF;
    if ((state_q == S_DRIVE) && shadow_en_q[idx_q]) begin
      seg_ah = lz_blank_c[idx_q] ? 7'h00 : hex_glyph(digit_c);
      seg_d  = seg_ah ^ SEG_OFF;
      dp_d   = shadow_dp_q[idx_q] ^ DP_OFF;
      an_d   = AN_OFF ^ (N_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= S_RST;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      shadow_en_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      upd_q        <= 1'b0;
      fd_q         <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_en_q  <= shadow_en_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      upd_q        <= upd_d;
      fd_q         <= fd_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg            = seg_q;
  assign seg_dp         = dp_q;
  assign anode          = an_q;
  assign frame_done     = fd_q;
  assign update_pending = upd_q;

endmodule

// File: tb/tb_mfp_multi_digit_seven_segment_scanner.sv
// Self-checking bench: cycle scoreboard against a behavioural model plus glyph vector table.
module tb_mfp_multi_digit_seven_segment_scanner;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  anode;
  logic        frame_done;
  logic        update_pending;

  mfp_multi_digit_seven_segment_scanner #(
    .N_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1), .ANODE_ACTIVE_LOW(1)
  ) dut (
    .SI_ClkIn(clk), .SI_Reset(rst), .load(load), .value(value), .dp(dp),
    .digit_en(digit_en), .seg(seg), .seg_dp(seg_dp), .anode(anode),
    .frame_done(frame_done), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       sdp;
    logic [3:0] an;
    logic       fd;
    logic       upd;
  } exp_t;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic [3:0][6:0] seg;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[7];
  int   n_cmp = 0;
  int   n_err = 0;

  int          m_cnt, m_idx;
  logic [15:0] m_sv, m_pv;
  logic [3:0]  m_sd, m_se, m_pd, m_pe;
  logic        m_upd;
  logic        upd_seen;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_upd = 1'b0;
    m_sv = '0; m_sd = '0; m_se = '0;
    m_pv = '0; m_pd = '0; m_pe = '0;
  endtask

  // One clock: predict outputs, push, clock, then pop and compare at the falling edge.
  task automatic tick();
    exp_t e, got;
    logic wrap;
    logic ok_oh;
    e = '{seg: 7'h7F, sdp: 1'b1, an: 4'hF, fd: 1'b0, upd: 1'b0};
    if (m_cnt >= BC && m_se[m_idx]) begin
      e.an[m_idx] = 1'b0;
      e.sdp = ~m_sd[m_idx];
      e.seg = ~glyph(m_sv[m_idx*4 +: 4]);
`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (m_idx != 0 && (m_sv >> (4*m_idx)) == 16'h0) e.seg = 7'h7F;
`endif
    end
    wrap = (m_cnt == SD-1) && (m_idx == ND-1);
    if (wrap) begin
      if (load) begin m_sv = value; m_sd = dp; m_se = digit_en; end
      else if (m_upd) begin m_sv = m_pv; m_sd = m_pd; m_se = m_pe; end
      m_upd = 1'b0;
    end else if (load) begin
      m_upd = 1'b1;
    end
    if (load) begin m_pv = value; m_pd = dp; m_pe = digit_en; end
    m_cnt = (m_cnt + 1) % SD;
    if (m_cnt == 0) m_idx = (m_idx + 1) % ND;
    e.fd  = (m_cnt == SD-1) && (m_idx == ND-1);
    e.upd = m_upd;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (update_pending === 1'b1) upd_seen = 1'b1;
    got = {seg, seg_dp, anode, frame_done, update_pending};
    e = sb_q.pop_front();
    cmp("scoreboard {seg,dp,an,fd,upd}", 32'(got), 32'(e));
    ok_oh = ($countones(~anode) <= 1);
    cmp("anode_onehot", 32'(ok_oh), 32'd1);
  endtask

  task automatic wait_fd(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = (frame_done === 1'b1);
    end
    cmp({tag, " frame_done_seen"}, 32'(found), 32'd1);
  endtask

  // Called in the frame_done cycle; checks the whole following frame digit by digit.
  task automatic check_frame(input logic [3:0][6:0] eseg, input logic [3:0] edp,
                             input logic [3:0] een, input string tag);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    tick();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      automatic int d   = k / 4;
      automatic int pos = k % 4;
      tick();
      if (pos < BC || !een[d]) begin
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end else begin
        ea = ~(4'b0001 << d); es = eseg[d]; ed = ~edp[d];
      end
      cmp($sformatf("%s anode d%0d p%0d", tag, d, pos), 32'(anode), 32'(ea));
      cmp($sformatf("%s seg d%0d p%0d", tag, d, pos), 32'(seg), 32'(es));
      cmp($sformatf("%s seg_dp d%0d p%0d", tag, d, pos), 32'(seg_dp), 32'(ed));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, blanks, act;
    bit fd_seen, found;
    vt[0] = '{16'h12AF, 4'b0001, 4'hF, {7'h79, 7'h24, 7'h08, 7'h0E}};
`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
    vt[1] = '{16'h0030, 4'b0000, 4'hF, {7'h7F, 7'h7F, 7'h30, 7'h40}};
    vt[2] = '{16'h0000, 4'b1000, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
`else
    vt[1] = '{16'h0030, 4'b0000, 4'hF, {7'h40, 7'h40, 7'h30, 7'h40}};
    vt[2] = '{16'h0000, 4'b1000, 4'hF, {7'h40, 7'h40, 7'h40, 7'h40}};
`endif
    vt[3] = '{16'hCB98, 4'b1111, 4'hF, {7'h46, 7'h03, 7'h10, 7'h00}};
    vt[4] = '{16'h7E64, 4'b0100, 4'hF, {7'h78, 7'h06, 7'h02, 7'h19}};
    vt[5] = '{16'h5555, 4'b1010, 4'b0101, {7'h12, 7'h12, 7'h12, 7'h12}};
    vt[6] = '{16'h1D01, 4'b0000, 4'hF, {7'h79, 7'h21, 7'h40, 7'h79}};

    rst = 1'b1; load = 1'b0; value = '0; dp = '0; digit_en = '0; upd_seen = 1'b0;
    model_reset();
    #1;
    cmp("reset anode", 32'(anode), 32'h0F);
    cmp("reset seg", 32'(seg), 32'h7F);
    cmp("reset seg_dp", 32'(seg_dp), 32'd1);
    cmp("reset frame_done", 32'(frame_done), 32'd0);
    cmp("reset update_pending", 32'(update_pending), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // First frame after load: blank cycle then three lit cycles of digit 0.
    value = 16'h12AF; dp = 4'b0001; digit_en = 4'hF; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd("first");
    tick();
    tick();
    cmp("first blank anode", 32'(anode), 32'h0F);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("first d0 anode", 32'(anode), 32'h0E);
      cmp("first d0 seg", 32'(seg), 32'h0E);
      cmp("first d0 seg_dp", 32'(seg_dp), 32'd0);
    end

    // Frame period and one dark cycle per slot.
    wait_fd("period sync");
    n = 0; blanks = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      n++;
      if (anode == 4'hF) blanks++;
      found = (frame_done === 1'b1);
    end
    cmp("frame period", 32'(n), 32'd16);
    cmp("dark cycles per frame", 32'(blanks), 32'd4);

    for (int i = 0; i < 7; i++) begin
      value = vt[i].val; dp = vt[i].dp; digit_en = vt[i].en; load = 1'b1;
      tick();
      load = 1'b0;
      wait_fd($sformatf("vec%0d", i));
      check_frame(vt[i].seg, vt[i].dp, vt[i].en, $sformatf("vec%0d", i));
    end

    // Two loads in one frame: last write wins, shown only from the next frame.
    wait_fd("overwrite sync");
    repeat (3) tick();
    value = 16'h1111; dp = 4'h0; digit_en = 4'hF; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    cmp("overwrite pending mid", 32'(update_pending), 32'd1);
    value = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd("overwrite");
    cmp("overwrite pending at end", 32'(update_pending), 32'd1);
    check_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'h0, 4'hF, "overwrite");
    cmp("overwrite pending cleared", 32'(update_pending), 32'd0);

    // Load in the frame_done cycle goes straight to the display.
    wait_fd("direct sync");
    value = 16'h3333; upd_seen = 1'b0; load = 1'b1;
    check_frame({7'h30, 7'h30, 7'h30, 7'h30}, 4'h0, 4'hF, "direct");
    cmp("direct pending never rose", 32'(upd_seen), 32'd0);

    // Asynchronous reset while digit 2 is lit, with a load still pending.
    wait_fd("reset sync");
    repeat (2) tick();
    value = 16'h4444; load = 1'b1;
    tick();
    load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = (m_idx == 2) && (m_cnt == 2);
    end
    cmp("reset reached digit 2", 32'(found), 32'd1);
    cmp("reset pre anode", 32'(anode), 32'h0B);
    cmp("reset pre pending", 32'(update_pending), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    cmp("async reset anode", 32'(anode), 32'h0F);
    cmp("async reset seg", 32'(seg), 32'h7F);
    cmp("async reset pending", 32'(update_pending), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    act = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (anode != 4'hF) act++;
    end
    cmp("post reset dark", 32'(act), 32'd0);
    value = 16'h0004; digit_en = 4'hF; dp = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    fd_seen = 1'b0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (frame_done === 1'b1) fd_seen = 1'b1;
      found = (anode != 4'hF);
    end
    cmp("post reset first anode", 32'(anode), 32'h0E);
    cmp("post reset after frame end", 32'(fd_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mfp_multi_digit_seven_segment_scanner.md
MFP_MULTI_DIGIT_SEVEN_SEGMENT_SCANNER -- requirements
Module: mfp_multi_digit_seven_segment_scanner

Interface
REQ-001 SHALL provide parameter N_DIGITS, default 8, number of multiplexed digits (legal range 1..16).
REQ-002 SHALL provide parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal minimum 2).
REQ-003 SHALL provide parameter BLANK_CYCLES, default 500, anode-off cycles at the start of each slot for anti-ghosting (legal range 0..SCAN_DIV-1).
REQ-004 SHALL provide parameter SEG_ACTIVE_LOW, default 1; 1 means segment/dp outputs drive 0 to light.
REQ-005 SHALL provide parameter ANODE_ACTIVE_LOW, default 1; 1 means anode outputs drive 0 to enable.
REQ-006 SHALL have port SI_ClkIn, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port SI_Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port load, input, 1 bit: strobe; capture value/dp/digit_en into the pending buffer.
REQ-009 SHALL have port value, input, 4*N_DIGITS bits: hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost.
REQ-010 SHALL have port dp, input, N_DIGITS bits: decimal point per digit.
REQ-011 SHALL have port digit_en, input, N_DIGITS bits: per-digit enable; a disabled digit keeps its anode inactive.
REQ-012 SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}.
REQ-013 SHALL have port seg_dp, output, 1 bit: decimal point segment.
REQ-014 SHALL have port anode, output, N_DIGITS bits: at most one active at a time.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of every full scan.
REQ-016 SHALL have port update_pending, output, 1 bit: high while a loaded frame awaits transfer to display.

Function
REQ-017 Slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index idx SHALL increment on each cnt wrap, wrapping from N_DIGITS-1 to 0.
REQ-018 The FSM SHALL have states BLANK (cnt < BLANK_CYCLES) and DRIVE (cnt >= BLANK_CYCLES); with BLANK_CYCLES=0, BLANK is never entered.
REQ-019 In BLANK all anodes and all segments SHALL be inactive; in DRIVE anode[idx] SHALL be active only if shadow digit_en[idx]=1.
REQ-020 In DRIVE, seg SHALL show hex glyph of shadow nibble idx (active-high codes 0=3F,1=06,2=5B,3=4F,A=77,F=71, standard for the rest), and seg_dp shall equal shadow dp[idx]; a disabled digit drives inactive segments.
REQ-021 seg, seg_dp and anode SHALL be registered, reflecting the cnt/idx state with exactly one cycle of latency; polarity applied per REQ-004/005.
REQ-022 frame_done SHALL pulse for exactly one cycle on the edge where idx wraps N_DIGITS-1 -> 0.
REQ-023 load=1 SHALL capture inputs into pending registers and set update_pending; a later load before frame end overwrites pending (last write wins).
REQ-024 At frame end with update_pending=1, pending SHALL copy to shadow and update_pending clear; shadow never changes mid-frame (no tearing).
REQ-025 load coinciding with frame end SHALL write the loaded inputs directly to shadow and leave update_pending=0.

Reset
REQ-026 On SI_Reset=1, asynchronously: cnt=0, idx=0, FSM=BLANK if BLANK_CYCLES>0 else DRIVE, shadow and pending all zero, update_pending=0, frame_done=0, all anodes/segments/dp inactive.
REQ-027 Reset asserted mid-slot or mid-frame SHALL discard pending data; after release, scanning restarts at digit 0, cnt 0.

Configuration
REQ-028 Macro MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN defined: zero nibbles above the most significant non-zero digit SHALL show inactive segments (dp still honoured); digit 0 always displays. Undefined: every enabled digit shows its nibble.

Verification
REQ-029 N_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, active-low: reset, load value=16'h12AF, dp=4'b0001, digit_en=4'hF -> after first frame_done, digit 0 slot shows anode=4'b1110, seg=7'h0E, seg_dp=0 for 3 cycles after 1 blank cycle.
REQ-030 Same config: frame_done period measured = 16 cycles; anode never has two active bits; 1 all-inactive cycle per slot.
REQ-031 Load 16'h1111 mid-frame then 16'h2222 before frame end -> current frame keeps old digits, next frame shows 2 on all digits (seg=7'h24), update_pending low after frame end.
REQ-032 load pulsed in the frame_done cycle with value=16'h3333 -> next frame shows 3 (seg=7'h30), update_pending never rises.
REQ-033 value=16'h0030, digit_en=4'hF: macro defined -> digits 3,2 all segments off, digit 1 seg=7'h30, digit 0 seg=7'h40; undefined -> digits 3,2 show 7'h40.
REQ-034 Assert SI_Reset in DRIVE of digit 2 -> anode all ones and update_pending=0 same cycle without clock; after release, first active anode is digit 0 only after a new load and frame end.
